// File: rtl/mpi_bus_master.sv
// rtl/mpi_bus_master.sv - MPI (Q-bus style) bus-cycle master; define MPI_TIMEOUT_EN for the RPLY timeout.
module mpi_bus_master #(
    parameter int SETUP   = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        pin_clk,
    input  logic        pin_rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    inout  wire  [15:0] pin_ad_n,
    output wire         pin_sync_n,
    output wire         pin_din_n,
    output wire         pin_dout_n,
    output wire         pin_wtbt_n,
    input  logic        pin_rply_n
);
    localparam int SW = (SETUP > 1) ? $clog2(SETUP) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, SYNC, DATA, RELEASE} state_t;

    state_t        state, next;
    logic [SW-1:0] setup_cnt;
    logic          lat_we;
    logic [15:1]   lat_addr;
    logic [15:0]   lat_wdata;
    logic          rply_m, rply_s;
    logic          ack_d, err_d, rd_latch, capture;
    logic          tmo_hit;

`ifdef MPI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    // Restarts on every state change, so DATA and RELEASE each get a full window.
    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            tmo_cnt <= '0;
        end else if (next != state) begin
            tmo_cnt <= '0;
        end else if (state == DATA || state == RELEASE) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        next     = state;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rd_latch = 1'b0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    next    = ADDR;
                end
            end
            ADDR: begin
                if (setup_cnt == SW'(SETUP - 1)) next = SYNC;
            end
            SYNC: next = DATA;
            DATA: begin
                if (rply_s) begin
                    rd_latch = !lat_we;
                    next     = RELEASE;
                end else if (tmo_hit) begin
                    next  = IDLE;
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end
            end
            RELEASE: begin
                if (!rply_s) begin
                    next  = IDLE;
                    ack_d = 1'b1;
                end else if (tmo_hit) begin
                    next  = IDLE;
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            state     <= IDLE;
            setup_cnt <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rply_m    <= 1'b0;
            rply_s    <= 1'b0;
            rdata     <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state  <= next;
            rply_m <= !pin_rply_n;
            rply_s <= rply_m;
            ack    <= ack_d;
            err    <= err_d;
            if (state == ADDR) setup_cnt <= setup_cnt + SW'(1);
            else               setup_cnt <= '0;
            if (capture) begin
                lat_we    <= we;
                lat_addr  <= addr[15:1];
                lat_wdata <= wdata;
            end
            if (rd_latch) rdata <= ~pin_ad_n;
        end
    end

    // Pins decode from the state register only; req never reaches them combinationally.
    logic        addr_phase, ad_oe, xfer_phase;
    logic [15:0] ad_val;

    assign busy       = (state != IDLE);
    assign addr_phase = (state == ADDR) || (state == SYNC);
    assign xfer_phase = (state == DATA) || (state == RELEASE);
    assign ad_oe      = addr_phase || (lat_we && xfer_phase);
    assign ad_val     = addr_phase ? ~{lat_addr, 1'b0} : ~lat_wdata;

    assign pin_ad_n   = ad_oe ? ad_val : 16'bz;
    assign pin_sync_n = (state == SYNC || xfer_phase) ? 1'b0 : 1'bz;
    assign pin_din_n  = (state == DATA && !lat_we) ? 1'b0 : 1'bz;
    assign pin_dout_n = (state == DATA && lat_we) ? 1'b0 : 1'bz;
    assign pin_wtbt_n = (addr_phase && lat_we) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_mpi_bus_master.sv
// tb/tb_mpi_bus_master.sv - directed bench for mpi_bus_master with ROM, write slave and stuck-RPLY slave.
module tb_mpi_bus_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        ack, err, busy;
    tri1  [15:0] ad_n;
    tri1         sync_n, din_n, dout_n, wtbt_n, rply_n;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mpi_bus_master #(.SETUP(1), .TIMEOUT(16)) dut (
        .pin_clk    (clk),
        .pin_rst_n  (rst_n),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ack        (ack),
        .err        (err),
        .busy       (busy),
        .pin_ad_n   (ad_n),
        .pin_sync_n (sync_n),
        .pin_din_n  (din_n),
        .pin_dout_n (dout_n),
        .pin_wtbt_n (wtbt_n),
        .pin_rply_n (rply_n)
    );

    // Passive slaves: ROM words at 0100000/0100002, write register at 0177700.
    logic [15:0] slave_addr = '0;
    logic [15:0] wr_store = '0;
    int          slave_delay = 0;
    int          strobe_cnt = 0;
    logic        hold_low = 1'b0;

    wire         din_low  = (din_n == 1'b0);
    wire         dout_low = (dout_n == 1'b0);
    wire         rom_sel  = (slave_addr == 16'o100000) || (slave_addr == 16'o100002);
    wire         wr_sel   = (slave_addr == 16'o177700);
    wire  [15:0] rom_word = (slave_addr == 16'o100000) ? 16'o012700 : 16'o000137;
    wire         rply_on  = hold_low ||
                            (((rom_sel && din_low) || (wr_sel && dout_low)) && (strobe_cnt >= slave_delay));

    assign rply_n = rply_on ? 1'b0 : 1'bz;
    assign ad_n   = (rom_sel && din_low) ? ~rom_word : 16'bz;

    always @(posedge clk) begin
        if (sync_n) slave_addr <= ~ad_n;
        strobe_cnt <= (din_low || dout_low) ? strobe_cnt + 1 : 0;
        if (wr_sel && dout_low && rply_on) wr_store <= ~ad_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency = rising edges after the accepting edge until ack is seen.
    task automatic run_cycle(input logic w, input logic [15:0] a, input logic [15:0] d,
                             input int release_at, output int lat, output int din_cyc,
                             output int wtbt_cyc, output int ad_bad);
        @(negedge clk);
        we = w; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; din_cyc = 0; wtbt_cyc = 0; ad_bad = 0;
        forever begin
            @(negedge clk);
            if (lat == release_at) hold_low = 1'b0;
            if (!din_n) din_cyc++;
            if (!wtbt_n) wtbt_cyc++;
            if (!dout_n && ad_n != ~d) ad_bad++;
            if (ack || lat >= 40) break;
            @(posedge clk);
            lat++;
        end
    endtask

    int          lat, din_cyc, wtbt_cyc, ad_bad, n;
    logic        saw_ack;
    logic [15:0] exp_ad, prev_rdata;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ad", ad_n, 16'hffff);
        check("rst_strobes", {sync_n, din_n, dout_n, wtbt_n}, 4'hf);
        rst_n = 1'b1;

        slave_delay = 0;
        run_cycle(1'b0, 16'o100000, 16'h0, -1, lat, din_cyc, wtbt_cyc, ad_bad);
        check("rd_lat", lat, 8);
        check("rd_data", rdata, 16'o012700);
        check("rd_din_cycles", din_cyc, 3);
        check("rd_wtbt_cycles", wtbt_cyc, 0);
        check("rd_rply_released", rply_n, 1);
        check("rd_err", err, 0);

        slave_delay = 5;
        run_cycle(1'b1, 16'o177700, 16'o052525, -1, lat, din_cyc, wtbt_cyc, ad_bad);
        check("wr_lat", lat, 13);
        check("wr_ad_bad", ad_bad, 0);
        check("wr_wtbt_cycles", wtbt_cyc, 2);
        check("wr_store", wr_store, 16'o052525);
        check("wr_din_cycles", din_cyc, 0);
        check("wr_rdata_kept", rdata, 16'o012700);

`ifdef MPI_TIMEOUT_EN
        slave_delay = 0;
        prev_rdata = rdata;
        run_cycle(1'b0, 16'o000000, 16'h0, -1, lat, din_cyc, wtbt_cyc, ad_bad);
        check("tmo_lat", lat, 18);
        check("tmo_err", err, 1);
        check("tmo_rdata", rdata, prev_rdata);
        check("tmo_ad", ad_n, 16'hffff);
        check("tmo_strobes", {sync_n, din_n, dout_n, wtbt_n}, 4'hf);
`endif

        slave_delay = 0;
        @(negedge clk);
        we = 1'b0; addr = 16'o100000; req = 1'b1;
        @(posedge clk);
        n = 0;
        @(negedge clk);
        while (!ack && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("b2b_lat1", n, 8);
        check("b2b_data1", rdata, 16'o012700);
        addr = 16'o100002;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        exp_ad = ~16'o100002;
        check("b2b_addr2", ad_n, exp_ad);
        check("b2b_busy2", busy, 1);
        check("b2b_sync2_high", sync_n, 1);
        n = 0;
        while (!ack && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("b2b_lat2", n, 8);
        check("b2b_data2", rdata, 16'o000137);

        slave_delay = 20;
        @(negedge clk);
        we = 1'b0; addr = 16'o100000; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("mid_din_low", din_n, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ad", ad_n, 16'hffff);
        check("mid_rst_strobes", {sync_n, din_n, dout_n, wtbt_n}, 4'hf);
        check("mid_rst_busy", busy, 0);
        saw_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        check("mid_rst_no_ack", saw_ack, 0);
        rst_n = 1'b1;
        slave_delay = 0;
        run_cycle(1'b0, 16'o100000, 16'h0, -1, lat, din_cyc, wtbt_cyc, ad_bad);
        check("post_rst_lat", lat, 8);
        check("post_rst_data", rdata, 16'o012700);

        @(negedge clk);
        hold_low = 1'b1;
        repeat (3) @(negedge clk);
        run_cycle(1'b0, 16'o100002, 16'h0, 6, lat, din_cyc, wtbt_cyc, ad_bad);
        check("stuck_lat", lat, 9);
        check("stuck_err", err, 0);
        check("stuck_data", rdata, 16'o000137);
        check("stuck_din_cycles", din_cyc, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mpi_bus_master.md
# mpi_bus_master

Clocked bus-cycle sequencer that turns a simple request/acknowledge port into asynchronous MPI (Q-bus style) transactions on the active-low multiplexed address/data bus. It runs the address phase, the SYNC/DIN/DOUT strobes and the RPLY handshake. It is the master that drives the ROM and other passive slaves in the system model. It replaces ad-hoc testbench tasks and feeds the later CPU and DMA front-ends.

## Interface
- `SETUP`, default 1: clocks the address is driven on `pin_ad_n` before `pin_sync_n` falls (≥1).
- `TIMEOUT`, default 64: clocks to wait for RPLY before a bus error (≥4).
- `pin_clk`  in  1  system clock; all state on the rising edge.
- `pin_rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request; sampled only in IDLE.
- `we`  in  1  1 = write cycle, 0 = read cycle.
- `addr`  in  16  byte address, true polarity; bit 0 ignored and driven as 0.
- `wdata`  in  16  write data, true polarity.
- `rdata`  out  16  read data, true polarity; valid while `ack` is high, held until the next read.
- `ack`  out  1  one-clock completion pulse.
- `err`  out  1  one-clock bus-error pulse; coincides with `ack`.
- `busy`  out  1  high in every state except IDLE.
- `pin_ad_n`  inout  16  multiplexed address/data, active-low; z when not driven.
- `pin_sync_n`, `pin_din_n`, `pin_dout_n`, `pin_wtbt_n`  out  1 each  open-drain strobes: 0 = asserted, z = released. The bench supplies pull-ups.
- `pin_rply_n`  in  1  slave reply, active-low, asynchronous to `pin_clk`.

## Operation
- `pin_rply_n` passes through a 2-flop synchronizer; `rply_s` denotes the second stage, true = asserted (low).
- FSM states: IDLE, ADDR, SYNC, DATA, RELEASE.
  - **IDLE**: all pins z. If `req`=1, capture `addr`, `we` and `wdata`, then go to ADDR.
  - **ADDR**: `pin_ad_n` = ~{addr[15:1],0}. `pin_wtbt_n`=0 if write. Stay SETUP clocks, then go to SYNC.
  - **SYNC**: assert `pin_sync_n`=0. Address and WTBT stay driven. One clock, then go to DATA.
  - **DATA**:
    - Read: `pin_ad_n`=z, `pin_din_n`=0.
    - Write: `pin_ad_n`=~wdata, `pin_dout_n`=0.
    - `pin_wtbt_n` is released (word transfer).
    - On the edge where `rply_s` is asserted: for a read, latch `rdata`=~`pin_ad_n`. Release DIN/DOUT and go to RELEASE.
  - **RELEASE**: `pin_sync_n` stays 0. Write data stays driven. On the edge where `rply_s` is deasserted: release all pins, pulse `ack`, go to IDLE.
- All strobes and `pin_ad_n` come from registered state; no combinational path from `req` to the pins.
- `req` held high across `ack` starts the next cycle on the first IDLE edge (back-to-back, no dead cycle beyond IDLE).
- `pin_rply_n` already low when DATA is entered is treated as an immediate reply, not as an error.

## Timing
- Reset values:
  - all pins z;
  - `ack`, `err` and `busy` = 0;
  - `rdata` = 0;
  - FSM in IDLE;
  - synchronizer flops = deasserted.
- Asynchronous reset mid-cycle releases every pin immediately with no `ack`. The slave sees SYNC rise and aborts.
- Accepting edge = E0. With SETUP=1: ADDR after E0, SYNC after E1, DATA after E2.
- With a zero-delay slave, the strobe sees `rply_s` at E5, RELEASE starts after E5, and IDLE with `ack`=1 follows E8.
- Read-to-ack latency is 8 clocks for SETUP=1. Each extra SETUP clock adds 1. Each clock of slave delay adds 1.
- The address is stable on `pin_ad_n` for at least one full clock after `pin_sync_n` falls. This satisfies slaves that latch while SYNC is high.
- `busy` rises after E0 and falls with `ack`.

## Configuration
- `MPI_TIMEOUT_EN` defined:
  - A counter clears on entry to DATA and again on entry to RELEASE.
  - If it reaches TIMEOUT-1 with no state exit, the FSM releases all pins, pulses `ack`=`err`=1, leaves `rdata` unchanged, and returns to IDLE.
  - A stuck-low RPLY in RELEASE also times out.
- `MPI_TIMEOUT_EN` undefined: no counter. The FSM waits indefinitely in DATA or RELEASE, and `err` is tied to 0.

## Test plan
- Preload the ROM word at 0100000 with 0012700 and read addr=16'o100000. Require:
  - `rdata`=16'o012700 with `ack` 8 clocks after acceptance (SETUP=1);
  - `pin_din_n` low only in DATA;
  - `pin_rply_n` back to z/1 before `ack`.
- Write 16'o052525 to a bench slave at 16'o177700 that replies after 5 clocks. Require:
  - `pin_ad_n`=~16'o052525 while `pin_dout_n`=0;
  - `pin_wtbt_n`=0 only during ADDR/SYNC;
  - `ack` 13 clocks after acceptance.
- With `MPI_TIMEOUT_EN` and TIMEOUT=16, read addr=16'o000000 with no slave present. Require `ack`=`err`=1 exactly 16 clocks after entering DATA, all pins z, and `rdata` unchanged.
- Hold `req` high for two reads at 16'o100000 and 16'o100002. Require the second ADDR phase to start one clock after the first `ack`, with two `ack` pulses and correct data each time.
- Assert `pin_rst_n`=0 during DATA of a read. Require all pins z in the same cycle, `busy`=0, no `ack`, and the next request to complete normally.
- Use a slave that holds RPLY low throughout, so it is already asserted at DATA entry. Require completion via RELEASE once RPLY deasserts, with `err`=0.
